// File: rtl/tulip_mix_pkg.sv
// rtl/tulip_mix_pkg.sv - shared types and helpers for the tulip wet/dry mixer
package tulip_mix_pkg;

  localparam int C_MIX_WIDTH = 16;

  typedef logic [C_MIX_WIDTH-1:0] mix_weight_t;

  typedef enum logic {
    STEADY = 1'b0,
    RAMP   = 1'b1
  } mix_state_t;

  // Unity weight for a given weight width: 1.0 in Q(width-1).
  function automatic int C_UNITY(input int width);
    return 1 << (width - 1);
  endfunction

  // Channel index width; a single-channel build still gets one bit.
  function automatic int chan_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tulip_mix_ramp.sv
// rtl/tulip_mix_ramp.sv - channel counter, target clamp and per-frame weight ramp
module tulip_mix_ramp
  import tulip_mix_pkg::*;
#(
  parameter int G_NUM_CHANNELS = 2,
  parameter int G_MIX_WIDTH    = 16,
  parameter int G_RAMP_LOG2    = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_enable,
  input  logic                                  i_bypass,
  input  logic [G_MIX_WIDTH-1:0]                i_mix_level,
  input  logic                                  i_accept,
  output logic [G_MIX_WIDTH-1:0]                o_w,
  output logic [chan_width(G_NUM_CHANNELS)-1:0] o_chan,
  output logic                                  o_busy
);

  localparam int C_CW       = chan_width(G_NUM_CHANNELS);
  localparam int C_U        = C_UNITY(G_MIX_WIDTH);
  localparam int C_STEP_RAW = C_U >> G_RAMP_LOG2;
  localparam int C_STEP     = (C_STEP_RAW == 0) ? 1 : C_STEP_RAW;
  localparam logic [G_MIX_WIDTH-1:0] C_U_W    = G_MIX_WIDTH'(C_U);
  localparam logic [G_MIX_WIDTH-1:0] C_STEP_W = G_MIX_WIDTH'(C_STEP);
  localparam logic [C_CW-1:0]        C_LAST   = C_CW'(G_NUM_CHANNELS - 1);

  logic [G_MIX_WIDTH-1:0] r_w;
  logic [C_CW-1:0]        r_chan;
  mix_state_t             r_state;
  mix_state_t             w_state_next;
  logic [G_MIX_WIDTH-1:0] w_target;
  logic [G_MIX_WIDTH-1:0] w_w_next;
  logic                   w_boundary;

  // The last channel of a frame closes it; that is where w may move.
  assign w_boundary = i_accept && (r_chan == C_LAST);

  // Clamp the target to unity and take at most one step toward it.
  always_comb begin
    w_target = i_bypass ? '0 : ((i_mix_level > C_U_W) ? C_U_W : i_mix_level);
    w_w_next = w_target;
    if (r_w < w_target) begin
      if ((w_target - r_w) > C_STEP_W) w_w_next = r_w + C_STEP_W;
    end else if ((r_w - w_target) > C_STEP_W) begin
      w_w_next = r_w - C_STEP_W;
    end
  end

  // Ramp state only changes on frame boundaries.
  always_comb begin
    w_state_next = r_state;
    if (w_boundary) begin
      case (r_state)
        STEADY:  if (r_w != w_target) w_state_next = RAMP;
        RAMP:    if (w_w_next == w_target) w_state_next = STEADY;
        default: w_state_next = STEADY;
      endcase
    end
  end

  // Counter, weight and state registers; enable=0 flushes like reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_enable) begin
      r_chan  <= '0;
      r_w     <= '0;
      r_state <= STEADY;
    end else begin
      r_state <= w_state_next;
      if (i_accept) r_chan <= (r_chan == C_LAST) ? '0 : r_chan + C_CW'(1);
      if (w_boundary) r_w <= w_w_next;
    end
  end

  assign o_w    = r_w;
  assign o_chan = r_chan;
  assign o_busy = (r_state == RAMP);

endmodule

// File: rtl/tulip_wet_dry_mixer.sv
// rtl/tulip_wet_dry_mixer.sv - dry/wet stream join and 2-stage crossfade MAC
module tulip_wet_dry_mixer
  import tulip_mix_pkg::*;
#(
  parameter int G_DWIDTH       = 24,
  parameter int G_NUM_CHANNELS = 2,
  parameter int G_MIX_WIDTH    = 16,
  parameter int G_RAMP_LOG2    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic                                  bypass,
  input  logic [G_MIX_WIDTH-1:0]                mix_level,
  input  logic [G_DWIDTH-1:0]                   dry_din,
  input  logic                                  dry_din_valid,
  output logic                                  dry_din_ready,
  input  logic [G_DWIDTH-1:0]                   wet_din,
  input  logic                                  wet_din_valid,
  output logic                                  wet_din_ready,
  output logic [G_DWIDTH-1:0]                   dout,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic [chan_width(G_NUM_CHANNELS)-1:0] dout_chan,
  output logic                                  busy
);

  localparam int C_CW = chan_width(G_NUM_CHANNELS);
  localparam int C_PW = G_DWIDTH + G_MIX_WIDTH;
  localparam logic [G_MIX_WIDTH-1:0] C_U_W = G_MIX_WIDTH'(C_UNITY(G_MIX_WIDTH));

  logic                   w_run;
  logic                   w_s2_adv;
  logic                   w_pipe_adv;
  logic                   w_accept;
  logic [G_MIX_WIDTH-1:0] w_w;
  logic [C_CW-1:0]        w_chan;
  logic signed [C_PW-1:0] w_dry_ext;
  logic signed [C_PW-1:0] w_wet_ext;
  logic signed [C_PW-1:0] w_kd;
  logic signed [C_PW-1:0] w_kw;
  logic signed [C_PW-1:0] w_pd;
  logic signed [C_PW-1:0] w_pw;
  logic signed [C_PW:0]   w_sum;
  logic [G_DWIDTH-1:0]    w_mix;

  logic                   r_s1_valid;
  logic signed [C_PW-1:0] r_pd;
  logic signed [C_PW-1:0] r_pw;
  logic [C_CW-1:0]        r_s1_chan;

  // Readies are held low while flushing so nothing is taken during reset.
  assign w_run         = reset_n & enable;
  assign w_s2_adv      = !dout_valid || dout_ready;
  assign w_pipe_adv    = !r_s1_valid || w_s2_adv;
  assign dry_din_ready = w_run & wet_din_valid & w_pipe_adv;
  assign wet_din_ready = w_run & dry_din_valid & w_pipe_adv;
  assign w_accept      = w_run & dry_din_valid & wet_din_valid & w_pipe_adv;

  tulip_mix_ramp #(
    .G_NUM_CHANNELS (G_NUM_CHANNELS),
    .G_MIX_WIDTH    (G_MIX_WIDTH),
    .G_RAMP_LOG2    (G_RAMP_LOG2)
  ) u_ramp (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_bypass    (bypass),
    .i_mix_level (mix_level),
    .i_accept    (w_accept),
    .o_w         (w_w),
    .o_chan      (w_chan),
    .o_busy      (busy)
  );

  // Weights are 0..U, so they enter the multipliers zero-extended (never negative).
  assign w_dry_ext = {{G_MIX_WIDTH{dry_din[G_DWIDTH-1]}}, dry_din};
  assign w_wet_ext = {{G_MIX_WIDTH{wet_din[G_DWIDTH-1]}}, wet_din};
  assign w_kd      = {{G_DWIDTH{1'b0}}, C_U_W - w_w};
  assign w_kw      = {{G_DWIDTH{1'b0}}, w_w};
  assign w_pd      = w_dry_ext * w_kd;
  assign w_pw      = w_wet_ext * w_kw;

  // Convex combination never exceeds the sample range, so truncation is safe.
  assign w_sum = (C_PW + 1)'(r_pd) + (C_PW + 1)'(r_pw);
  assign w_mix = G_DWIDTH'(w_sum >>> (G_MIX_WIDTH - 1));

  // Stage 1: products with the weight and channel captured at accept.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_s1_valid <= 1'b0;
      r_pd       <= '0;
      r_pw       <= '0;
      r_s1_chan  <= '0;
    end else if (w_pipe_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_pd      <= w_pd;
        r_pw      <= w_pw;
        r_s1_chan <= w_chan;
      end
    end
  end

  // Stage 2: sum, floor-shift back to sample scale, hold while stalled.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_chan  <= '0;
    end else if (w_s2_adv) begin
      dout_valid <= r_s1_valid;
      if (r_s1_valid) begin
        dout      <= w_mix;
        dout_chan <= r_s1_chan;
      end
    end
  end

endmodule

// File: tb/tb_tulip_wet_dry_mixer.sv
// tb/tb_tulip_wet_dry_mixer.sv - scoreboard bench for the tulip wet/dry mixer
module tb_tulip_wet_dry_mixer;

  localparam int N    = 2;
  localparam int DW   = 24;
  localparam int MW   = 16;
  localparam int RL   = 4;
  localparam int U    = 32768;
  localparam int STEP = 2048;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          bypass;
  logic [MW-1:0] mix_level;
  logic [DW-1:0] dry_din;
  logic          dry_din_valid;
  logic          dry_din_ready;
  logic [DW-1:0] wet_din;
  logic          wet_din_valid;
  logic          wet_din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [0:0]    dout_chan;
  logic          busy;

  always #5 clk = ~clk;

  tulip_wet_dry_mixer #(
    .G_DWIDTH       (DW),
    .G_NUM_CHANNELS (N),
    .G_MIX_WIDTH    (MW),
    .G_RAMP_LOG2    (RL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bypass        (bypass),
    .mix_level     (mix_level),
    .dry_din       (dry_din),
    .dry_din_valid (dry_din_valid),
    .dry_din_ready (dry_din_ready),
    .wet_din       (wet_din),
    .wet_din_valid (wet_din_valid),
    .wet_din_ready (wet_din_ready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_chan     (dout_chan),
    .busy          (busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [0:0]    c;
  } exp_t;

  exp_t sb_q[$];
  int   outs[$];
  int   out_chans[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_w      = 0;
  int   m_chan   = 0;
  int   m_busy   = 0;
  int   n_acc    = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference mix: exact rational value floored toward -inf.
  function automatic int mix_ref(input int dry, input int wet, input int w);
    longint num;
    num = longint'(dry) * (U - w) + longint'(wet) * w;
    if (num >= 0) return int'(num / U);
    return -int'((-num + U - 1) / U);
  endfunction

  // Monitor: compare presented outputs, then record the handshakes of the coming edge.
  always @(negedge clk) begin
    exp_t e;
    int   t;
    int   d;
    int   nw;
    check("busy", busy, m_busy);
    if (dout_valid) begin
      if (sb_q.size() == 0) begin
        check("dout_valid_without_expected", dout_valid, 0);
      end else begin
        check("dout", $signed(dout), $signed(sb_q[0].d));
        check("dout_chan", dout_chan, sb_q[0].c);
      end
    end
    if (!reset_n || !enable) begin
      sb_q.delete();
      m_w    = 0;
      m_chan = 0;
      m_busy = 0;
    end else begin
      if (dout_valid && dout_ready && sb_q.size() > 0) begin
        void'(sb_q.pop_front());
        outs.push_back(int'($signed(dout)));
        out_chans.push_back(int'(dout_chan));
      end
      if (dry_din_valid && dry_din_ready && wet_din_valid && wet_din_ready) begin
        e.d = DW'(mix_ref($signed(dry_din), $signed(wet_din), m_w));
        e.c = 1'(m_chan);
        sb_q.push_back(e);
        n_acc++;
        if (m_chan == N - 1) begin
          t  = bypass ? 0 : ((int'(mix_level) > U) ? U : int'(mix_level));
          d  = t - m_w;
          if (d > STEP) d = STEP;
          if (d < -STEP) d = -STEP;
          nw = m_w + d;
          if (m_busy == 0 && m_w != t) m_busy = 1;
          else if (m_busy == 1 && nw == t) m_busy = 0;
          m_w    = nw;
          m_chan = 0;
        end else begin
          m_chan++;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_checks(input string tag);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dout_chan"}, dout_chan, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dry_ready"}, dry_din_ready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int start;
    int cyc;
    reset_n       = 1'b0;
    enable        = 1'b1;
    bypass        = 1'b0;
    mix_level     = 16'h8000;
    dry_din       = DW'(1000);
    wet_din       = DW'(-1000);
    dry_din_valid = 1'b1;
    wet_din_valid = 1'b1;
    dout_ready    = 1'b1;
    tick(3);
    flush_checks("reset");
    check("reset_wet_ready", wet_din_ready, 0);

    // Startup ramp: 1000 -> -1000 in steps of 125 per frame.
    outs.delete();
    out_chans.delete();
    reset_n = 1'b1;
    tick(10);
    check("t1_busy_mid", busy, 1);
    tick(30);
    check("t1_count", outs.size() >= 34, 1);
    check("t1_f0_ch0", outs[0], 1000);
    check("t1_f0_ch0_chan", out_chans[0], 0);
    check("t1_f0_ch1", outs[1], 1000);
    check("t1_f0_ch1_chan", out_chans[1], 1);
    check("t1_f1", outs[2], 875);
    check("t1_f8", outs[16], 0);
    check("t1_f15", outs[30], -875);
    check("t1_f16_ch0", outs[32], -1000);
    check("t1_f16_ch1", outs[33], -1000);
    check("t1_busy_end", busy, 0);

    // Bypass ramp-down back to dry.
    outs.delete();
    out_chans.delete();
    bypass = 1'b1;
    tick(10);
    check("t2_busy_mid", busy, 1);
    tick(30);
    viol = 0;
    for (int i = 1; i < outs.size(); i++) if (outs[i] < outs[i-1]) viol++;
    check("t2_monotonic", viol, 0);
    check("t2_first", outs[0], -1000);
    check("t2_final", outs[outs.size()-1], 1000);
    check("t2_busy_end", busy, 0);

    // Join: no wet sample means no dry sample either.
    wet_din_valid = 1'b0;
    tick(4);
    viol = outs.size();
    check("t3_dry_ready", dry_din_ready, 0);
    check("t3_wet_ready", wet_din_ready, 1);
    tick(4);
    check("t3_no_output", outs.size(), viol);
    check("t3_no_valid", dout_valid, 0);

    // Backpressure: stall for 10 cycles with changing data.
    wet_din_valid = 1'b1;
    dout_ready    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dry_din = DW'(100 * i);
      wet_din = DW'(-37 * i);
      tick();
    end
    check("t3_stall_valid", dout_valid, 1);
    check("t3_stall_ready", dry_din_ready, 0);
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dry_din = DW'(5000 - 77 * i);
      wet_din = DW'(313 * i);
      tick();
    end

    // Random valid/ready traffic with occasional target changes.
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < 10000 && cyc < 50000) begin
      dry_din_valid = ($urandom_range(3) != 0);
      wet_din_valid = ($urandom_range(3) != 0);
      dout_ready    = ($urandom_range(9) < 7);
      dry_din       = DW'($urandom);
      wet_din       = DW'($urandom);
      if ($urandom_range(499) == 0) bypass = ~bypass;
      if ($urandom_range(499) == 0) mix_level = MW'($urandom);
      tick();
      cyc++;
    end
    check("t3_random_budget", (n_acc - start) >= 10000, 1);
    dry_din_valid = 1'b0;
    wet_din_valid = 1'b0;
    dout_ready    = 1'b1;
    tick(5);
    check("t3_random_drained", sb_q.size(), 0);

    // Arithmetic edge: full-scale opposite samples at half weight floor to -1.
    reset_n = 1'b0;
    tick(2);
    reset_n       = 1'b1;
    bypass        = 1'b0;
    mix_level     = 16'd16384;
    dry_din       = DW'(1000);
    wet_din       = DW'(-1000);
    dry_din_valid = 1'b1;
    wet_din_valid = 1'b1;
    tick(30);
    check("t4_busy", busy, 0);
    outs.delete();
    dry_din = 24'h7FFFFF;
    wet_din = 24'h800000;
    tick(6);
    dry_din_valid = 1'b0;
    wet_din_valid = 1'b0;
    tick(4);
    check("t4_floor", outs[outs.size()-1], -1);

    // Clamp: oversize mix level ends fully wet.
    outs.delete();
    mix_level     = 16'hFFFF;
    dry_din       = DW'(12345);
    wet_din       = DW'(-777);
    dry_din_valid = 1'b1;
    wet_din_valid = 1'b1;
    tick(40);
    check("t5_busy", busy, 0);
    check("t5_wet_last", outs[outs.size()-1], -777);
    check("t5_wet_prev", outs[outs.size()-2], -777);

    // Mid-ramp, mid-frame flush by reset_n and then by enable.
    reset_n = 1'b0;
    tick(2);
    reset_n   = 1'b1;
    mix_level = 16'h8000;
    dry_din   = DW'(1000);
    wet_din   = DW'(-1000);
    tick(7);
    check("t6_pre_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    flush_checks("t6_rst");
    reset_n = 1'b1;
    outs.delete();
    out_chans.delete();
    tick(6);
    check("t6_rst_first", outs[0], 1000);
    check("t6_rst_first_chan", out_chans[0], 0);
    tick(7);
    check("t6_pre_busy_en", busy, 1);
    enable = 1'b0;
    tick();
    flush_checks("t6_en");
    enable = 1'b1;
    outs.delete();
    out_chans.delete();
    tick(6);
    check("t6_en_first", outs[0], 1000);
    check("t6_en_first_chan", out_chans[0], 0);

    dry_din_valid = 1'b0;
    wet_din_valid = 1'b0;
    tick(5);
    check("final_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
